// File: rtl/axis_mul8_stream_adapter.sv
// AXI-Stream wrapper around a 3-stage pipelined 8x8 unsigned multiplier.
// Operand beats {a,b} enter on s_axis and products leave on m_axis, with tlast
// carried alongside each product. Credit counting bounds the number of beats in
// flight plus buffered to DEPTH, so the non-stallable multiplier never overruns
// the output FIFO.
// Optional feature: define AXIS_MUL_PERF_CNT_EN to add beat_cnt_o/stall_cnt_o.

// 3-stage pipelined 8x8 unsigned multiplier with no stall input.
// valid_o/p_o rise after the third edge counted from the edge that samples en.
module wallace8_spst_pipe3 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [7:0]  a_i,
    input  logic [7:0]  b_i,
    output logic [15:0] p_o,
    output logic        valid_o
);

    logic [11:0] pp_lo;
    logic [11:0] pp_hi;
    logic        v1;
    logic [15:0] sum2;
    logic        v2;

    // Stage 1: two 8x4 partial products (low and high nibble of b).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pp_lo <= '0;
            pp_hi <= '0;
            v1    <= 1'b0;
        end else begin
            pp_lo <= {4'b0, a_i} * {8'b0, b_i[3:0]};
            pp_hi <= {4'b0, a_i} * {8'b0, b_i[7:4]};
            v1    <= en;
        end
    end

    // Stage 2: combine partial products into the full 16-bit sum.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum2 <= '0;
            v2   <= 1'b0;
        end else begin
            sum2 <= {4'b0, pp_lo} + {pp_hi, 4'b0};
            v2   <= v1;
        end
    end

    // Stage 3: registered product output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_o     <= '0;
            valid_o <= 1'b0;
        end else begin
            p_o     <= sum2;
            valid_o <= v2;
        end
    end

endmodule

module axis_mul8_stream_adapter #(
    parameter int unsigned MUL_LAT = 3,
    parameter int unsigned DEPTH   = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] s_axis_tdata,
    input  logic        s_axis_tvalid,
    input  logic        s_axis_tlast,
    output logic        s_axis_tready,
    output logic [15:0] m_axis_tdata,
    output logic        m_axis_tvalid,
    output logic        m_axis_tlast,
    input  logic        m_axis_tready
`ifdef AXIS_MUL_PERF_CNT_EN
    ,
    output logic [31:0] beat_cnt_o,
    output logic [31:0] stall_cnt_o
`endif
);

    localparam int unsigned OW = $clog2(DEPTH + 1);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [OW-1:0] DEPTH_C = OW'(DEPTH);
    localparam logic [PW-1:0] PTR_MAX = PW'(DEPTH - 1);

    logic               ready_en;
    logic [OW-1:0]      occ;
    logic               acc;
    logic               pop;
    logic [MUL_LAT-1:0] last_line;
    logic [15:0]        mul_p;
    logic               mul_valid;

    logic [16:0]        mem [DEPTH];
    logic [PW-1:0]      wr_ptr;
    logic [PW-1:0]      rd_ptr;
    logic [OW-1:0]      cnt;
    logic               fifo_wr;
    logic               xfer;

    assign s_axis_tready = ready_en && (occ < DEPTH_C);
    assign acc           = s_axis_tvalid && s_axis_tready;
    assign pop           = m_axis_tvalid && m_axis_tready;
    assign fifo_wr       = mul_valid;
    // The m_axis register is the last FIFO slot: it refills from memory when it
    // is empty or being popped. Memory contents written this edge are not
    // forwarded, so the head appears one cycle after the write.
    assign xfer          = (cnt != '0) && (!m_axis_tvalid || pop);

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PTR_MAX) ? '0 : p + PW'(1);
    endfunction

    wallace8_spst_pipe3 u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (acc),
        .a_i     (s_axis_tdata[15:8]),
        .b_i     (s_axis_tdata[7:0]),
        .p_o     (mul_p),
        .valid_o (mul_valid)
    );

    // Input acceptance enables on the first edge after reset is released.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ready_en <= 1'b0;
        else        ready_en <= 1'b1;
    end

    // Credits: beats in the multiplier plus beats held in the FIFO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ <= '0;
        end else begin
            case ({acc, pop})
                2'b10:   occ <= occ + OW'(1);
                2'b01:   occ <= occ - OW'(1);
                default: occ <= occ;
            endcase
        end
    end

    // tlast sideband delayed to line up with the multiplier's valid_o.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_line <= '0;
        end else begin
            last_line[0] <= acc && s_axis_tlast;
            for (int unsigned i = 1; i < MUL_LAT; i++) begin
                last_line[i] <= last_line[i-1];
            end
        end
    end

    // FIFO storage, pointers, entry count and the registered m_axis head.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            cnt           <= '0;
            m_axis_tdata  <= '0;
            m_axis_tlast  <= 1'b0;
            m_axis_tvalid <= 1'b0;
        end else begin
            if (fifo_wr) begin
                mem[wr_ptr] <= {last_line[MUL_LAT-1], mul_p};
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (xfer) begin
                {m_axis_tlast, m_axis_tdata} <= mem[rd_ptr];
                rd_ptr        <= ptr_inc(rd_ptr);
                m_axis_tvalid <= 1'b1;
            end else if (pop) begin
                m_axis_tvalid <= 1'b0;
            end
            case ({fifo_wr, xfer})
                2'b10:   cnt <= cnt + OW'(1);
                2'b01:   cnt <= cnt - OW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // A product arriving at a full memory would be lost; credits must prevent it.
    assert property (@(posedge clk) disable iff (!rst_n)
        !(fifo_wr && (cnt == DEPTH_C) && !xfer));

`ifdef AXIS_MUL_PERF_CNT_EN
    // Handshake and stall-cycle counters, free-running and wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt_o  <= '0;
            stall_cnt_o <= '0;
        end else begin
            if (pop)                            beat_cnt_o  <= beat_cnt_o + 32'd1;
            if (m_axis_tvalid && !m_axis_tready) stall_cnt_o <= stall_cnt_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_axis_mul8_stream_adapter.sv
// Directed and randomized bench for axis_mul8_stream_adapter.
// Inputs are driven and outputs sampled 1 ns after each rising edge.
module tb_axis_mul8_stream_adapter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] s_axis_tdata;
    logic        s_axis_tvalid;
    logic        s_axis_tlast;
    logic        s_axis_tready;
    logic [15:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tlast;
    logic        m_axis_tready;
`ifdef AXIS_MUL_PERF_CNT_EN
    logic [31:0] beat_cnt_o;
    logic [31:0] stall_cnt_o;
`endif

    int unsigned pass_cnt  = 0;
    int unsigned total_cnt = 0;

    always #5 clk = ~clk;

    axis_mul8_stream_adapter #(.MUL_LAT(3), .DEPTH(8)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tready (m_axis_tready)
`ifdef AXIS_MUL_PERF_CNT_EN
        ,
        .beat_cnt_o    (beat_cnt_o),
        .stall_cnt_o   (stall_cnt_o)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; s_axis_tvalid = 1'b0; s_axis_tdata = '0; s_axis_tlast = 1'b0;
        m_axis_tready = 1'b0;
        repeat (3) tick();
        total_cnt++;
        if (s_axis_tready !== 1'b0) $display("FAIL reset_s_tready: got %b want 0", s_axis_tready);
        else pass_cnt++;
        total_cnt++;
        if (m_axis_tvalid !== 1'b0) $display("FAIL reset_m_tvalid: got %b want 0", m_axis_tvalid);
        else pass_cnt++;
        total_cnt++;
        if (m_axis_tdata !== 16'h0) $display("FAIL reset_m_tdata: got %h want 0000", m_axis_tdata);
        else pass_cnt++;
        total_cnt++;
        if (m_axis_tlast !== 1'b0) $display("FAIL reset_m_tlast: got %b want 0", m_axis_tlast);
        else pass_cnt++;
        rst_n = 1'b1;
        #1;
        total_cnt++;
        if (s_axis_tready !== 1'b0) $display("FAIL release_s_tready_early: got %b want 0", s_axis_tready);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (s_axis_tready !== 1'b1) $display("FAIL release_s_tready: got %b want 1", s_axis_tready);
        else pass_cnt++;
    endtask

    task automatic test_single_beat();
        m_axis_tready = 1'b1;
        s_axis_tvalid = 1'b1; s_axis_tdata = 16'h55AA; s_axis_tlast = 1'b1;
        total_cnt++;
        if (s_axis_tready !== 1'b1) $display("FAIL single_s_ready: got %b want 1", s_axis_tready);
        else pass_cnt++;
        tick();
        s_axis_tvalid = 1'b0; s_axis_tdata = '0; s_axis_tlast = 1'b0;
        for (int k = 0; k < 4; k++) begin
            total_cnt++;
            if (m_axis_tvalid !== 1'b0)
                $display("FAIL single_early_valid: edge+%0d got %b want 0", k, m_axis_tvalid);
            else pass_cnt++;
            tick();
        end
        total_cnt++;
        if (m_axis_tvalid !== 1'b1) $display("FAIL single_valid_at_4: got %b want 1", m_axis_tvalid);
        else pass_cnt++;
        total_cnt++;
        if (m_axis_tdata !== 16'h3872) $display("FAIL single_data: got %h want 3872", m_axis_tdata);
        else pass_cnt++;
        total_cnt++;
        if (m_axis_tlast !== 1'b1) $display("FAIL single_last: got %b want 1", m_axis_tlast);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (m_axis_tvalid !== 1'b0) $display("FAIL single_after_pop: got %b want 0", m_axis_tvalid);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic [7:0]  a_v   [6];
        logic [7:0]  b_v   [6];
        logic [15:0] exp_p [6];
        int idx;
        a_v   = '{8'd255, 8'd128, 8'd200, 8'd7, 8'd0, 8'd255};
        b_v   = '{8'd1, 8'd2, 8'd50, 8'd13, 8'd150, 8'd255};
        exp_p = '{16'd255, 16'd256, 16'd10000, 16'd91, 16'd0, 16'd65025};
        idx = 0;
        m_axis_tready = 1'b1;
        for (int cyc = 0; cyc < 14; cyc++) begin
            if (cyc < 6) begin
                s_axis_tvalid = 1'b1;
                s_axis_tdata  = {a_v[cyc], b_v[cyc]};
                s_axis_tlast  = (cyc == 5);
                total_cnt++;
                if (s_axis_tready !== 1'b1) $display("FAIL b2b_s_ready: beat %0d got %b want 1", cyc, s_axis_tready);
                else pass_cnt++;
            end else begin
                s_axis_tvalid = 1'b0; s_axis_tdata = '0; s_axis_tlast = 1'b0;
            end
            tick();
            if (m_axis_tvalid === 1'b1) begin
                total_cnt++;
                if (idx >= 6) begin
                    $display("FAIL b2b_extra_beat: got %h want none", m_axis_tdata);
                end else if (m_axis_tdata !== exp_p[idx] || m_axis_tlast !== (idx == 5) || cyc != idx + 4) begin
                    $display("FAIL b2b_beat%0d: got %0d last %b at cyc %0d want %0d last %b at cyc %0d",
                             idx, m_axis_tdata, m_axis_tlast, cyc, exp_p[idx], (idx == 5), idx + 4);
                end else pass_cnt++;
                idx++;
            end
        end
        total_cnt++;
        if (idx != 6) $display("FAIL b2b_count: got %0d want 6", idx);
        else pass_cnt++;
    endtask

    task automatic test_backpressure();
        logic [7:0]  bp_a  [12];
        logic [7:0]  bp_b  [12];
        logic        bp_l  [12];
        logic [15:0] exp_p [12];
        int acc_n, out_n;
        for (int i = 0; i < 12; i++) begin
            bp_a[i]  = 8'(20 + i * 9);
            bp_b[i]  = 8'(3 + i * 17);
            bp_l[i]  = (i % 3 == 0);
            exp_p[i] = 16'(bp_a[i]) * 16'(bp_b[i]);
        end
        acc_n = 0;
        out_n = 0;
        m_axis_tready = 1'b0;
        for (int c = 0; c < 30; c++) begin
            if (acc_n >= 12) break;
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = {bp_a[acc_n], bp_b[acc_n]};
            s_axis_tlast  = bp_l[acc_n];
            if (s_axis_tready !== 1'b1) break;
            acc_n++;
            tick();
        end
        total_cnt++;
        if (acc_n != 8) $display("FAIL bp_accepts_before_full: got %0d want 8", acc_n);
        else pass_cnt++;
        for (int c = 0; c < 5; c++) begin
            tick();
            total_cnt++;
            if (s_axis_tready !== 1'b0) $display("FAIL bp_s_ready_full: got %b want 0", s_axis_tready);
            else pass_cnt++;
            total_cnt++;
            if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== exp_p[0] || m_axis_tlast !== bp_l[0])
                $display("FAIL bp_stall_hold: got v%b %0d l%b want v1 %0d l%b",
                         m_axis_tvalid, m_axis_tdata, m_axis_tlast, exp_p[0], bp_l[0]);
            else pass_cnt++;
        end
        m_axis_tready = 1'b1;
        for (int c = 0; c < 80 && out_n < 12; c++) begin
            if (m_axis_tvalid === 1'b1) begin
                total_cnt++;
                if (m_axis_tdata !== exp_p[out_n] || m_axis_tlast !== bp_l[out_n])
                    $display("FAIL bp_beat%0d: got %0d last %b want %0d last %b",
                             out_n, m_axis_tdata, m_axis_tlast, exp_p[out_n], bp_l[out_n]);
                else pass_cnt++;
                out_n++;
            end
            if (acc_n < 12) begin
                s_axis_tvalid = 1'b1;
                s_axis_tdata  = {bp_a[acc_n], bp_b[acc_n]};
                s_axis_tlast  = bp_l[acc_n];
                if (s_axis_tready === 1'b1) acc_n++;
            end else begin
                s_axis_tvalid = 1'b0; s_axis_tdata = '0; s_axis_tlast = 1'b0;
            end
            tick();
        end
        s_axis_tvalid = 1'b0; s_axis_tdata = '0; s_axis_tlast = 1'b0;
        total_cnt++;
        if (out_n != 12 || acc_n != 12) $display("FAIL bp_drain: got out %0d acc %0d want 12 12", out_n, acc_n);
        else pass_cnt++;
    endtask

    task automatic test_random();
        logic [15:0] q_p [$];
        logic        q_l [$];
        int   occ_m, got, sent;
        logic have;
        logic [7:0] ca, cb;
        logic cl;
        occ_m = 0; got = 0; sent = 0; have = 1'b0; ca = '0; cb = '0; cl = 1'b0;
        for (int c = 0; c < 20000 && got < 1000; c++) begin
            total_cnt++;
            if (s_axis_tready !== 1'(occ_m < 8))
                $display("FAIL rand_s_ready: cyc %0d got %b want %b (occ %0d)", c, s_axis_tready, (occ_m < 8), occ_m);
            else pass_cnt++;
            m_axis_tready = 1'($urandom_range(0, 1));
            if (m_axis_tvalid === 1'b1 && m_axis_tready) begin
                total_cnt++;
                if (q_p.size() == 0) begin
                    $display("FAIL rand_extra_beat: got %0d want none", m_axis_tdata);
                end else begin
                    if (m_axis_tdata !== q_p[0] || m_axis_tlast !== q_l[0])
                        $display("FAIL rand_beat%0d: got %0d last %b want %0d last %b",
                                 got, m_axis_tdata, m_axis_tlast, q_p[0], q_l[0]);
                    else pass_cnt++;
                    void'(q_p.pop_front());
                    void'(q_l.pop_front());
                end
                occ_m--;
                got++;
            end
            if (!have && sent < 1000 && $urandom_range(0, 1) == 1) begin
                ca = 8'($urandom);
                cb = 8'($urandom);
                cl = 1'($urandom_range(0, 1));
                have = 1'b1;
            end
            s_axis_tvalid = have;
            s_axis_tdata  = {ca, cb};
            s_axis_tlast  = cl;
            if (have && s_axis_tready === 1'b1) begin
                q_p.push_back(16'(ca) * 16'(cb));
                q_l.push_back(cl);
                occ_m++;
                sent++;
                have = 1'b0;
            end
            tick();
        end
        s_axis_tvalid = 1'b0; s_axis_tdata = '0; s_axis_tlast = 1'b0;
        m_axis_tready = 1'b1;
        total_cnt++;
        if (got != 1000 || q_p.size() != 0)
            $display("FAIL rand_drain: got %0d left %0d want 1000 0", got, q_p.size());
        else pass_cnt++;
    endtask

    task automatic test_reset_midstream();
        bit found;
        m_axis_tready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = {8'(i + 1), 8'(i + 2)};
            s_axis_tlast  = 1'b1;
            tick();
        end
        s_axis_tvalid = 1'b0; s_axis_tdata = '0; s_axis_tlast = 1'b0;
        total_cnt++;
        if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 16'd2) $display("FAIL mid_buffered: got v%b %0d want v1 2", m_axis_tvalid, m_axis_tdata);
        else pass_cnt++;
        rst_n = 1'b0;
        #1;
        total_cnt++;
        if (m_axis_tvalid !== 1'b0) $display("FAIL mid_reset_valid: got %b want 0", m_axis_tvalid);
        else pass_cnt++;
        total_cnt++;
        if (s_axis_tready !== 1'b0) $display("FAIL mid_reset_s_ready: got %b want 0", s_axis_tready);
        else pass_cnt++;
        tick();
        tick();
        rst_n = 1'b1;
        m_axis_tready = 1'b1;
        tick();
        for (int c = 0; c < 12; c++) begin
            total_cnt++;
            if (m_axis_tvalid !== 1'b0) $display("FAIL mid_stale_beat: got %0d want none", m_axis_tdata);
            else pass_cnt++;
            tick();
        end
        s_axis_tvalid = 1'b1; s_axis_tdata = 16'h0F0F; s_axis_tlast = 1'b0;
        total_cnt++;
        if (s_axis_tready !== 1'b1) $display("FAIL mid_new_s_ready: got %b want 1", s_axis_tready);
        else pass_cnt++;
        tick();
        s_axis_tvalid = 1'b0; s_axis_tdata = '0;
        found = 1'b0;
        for (int c = 0; c < 10 && !found; c++) begin
            if (m_axis_tvalid === 1'b1) found = 1'b1;
            else tick();
        end
        total_cnt++;
        if (!found || m_axis_tdata !== 16'd225) $display("FAIL mid_new_beat: got v%b %0d want v1 225", found, m_axis_tdata);
        else pass_cnt++;
        tick();
    endtask

`ifdef AXIS_MUL_PERF_CNT_EN
    task automatic test_perf_counters();
        int sent, got, stall;
        m_axis_tready = 1'b1;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        total_cnt++;
        if (beat_cnt_o !== 32'd0 || stall_cnt_o !== 32'd0)
            $display("FAIL perf_reset: got %0d %0d want 0 0", beat_cnt_o, stall_cnt_o);
        else pass_cnt++;
        sent = 0; got = 0; stall = 0;
        for (int c = 0; c < 100 && got < 10; c++) begin
            if (m_axis_tvalid === 1'b1 && stall < 5) begin
                m_axis_tready = 1'b0;
                stall++;
            end else begin
                m_axis_tready = 1'b1;
                if (m_axis_tvalid === 1'b1) got++;
            end
            if (sent < 10) begin
                s_axis_tvalid = 1'b1;
                s_axis_tdata  = {8'(sent + 3), 8'(sent + 5)};
                s_axis_tlast  = 1'b0;
                if (s_axis_tready === 1'b1) sent++;
            end else begin
                s_axis_tvalid = 1'b0; s_axis_tdata = '0;
            end
            tick();
        end
        s_axis_tvalid = 1'b0;
        m_axis_tready = 1'b1;
        total_cnt++;
        if (beat_cnt_o !== 32'd10) $display("FAIL perf_beat_cnt: got %0d want 10", beat_cnt_o);
        else pass_cnt++;
        total_cnt++;
        if (stall_cnt_o !== 32'd5) $display("FAIL perf_stall_cnt: got %0d want 5", stall_cnt_o);
        else pass_cnt++;
    endtask
`endif

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; s_axis_tvalid = 1'b0; s_axis_tdata = '0; s_axis_tlast = 1'b0;
        m_axis_tready = 1'b0;
        test_reset();
        test_single_beat();
        test_back_to_back();
        test_backpressure();
        test_random();
        test_reset_midstream();
`ifdef AXIS_MUL_PERF_CNT_EN
        test_perf_counters();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/axis_mul8_stream_adapter.md
Name: axis_mul8_stream_adapter

Overview:
- AXI-Stream front/back end for the 3-stage pipelined 8x8 Wallace multiplier (wallace8_spst_pipe3), which has no stall input.
- Accepts operand beats on a slave AXI-Stream port and drives the multiplier's en/a_i/b_i.
- Captures p_o/valid_o into an output FIFO and presents products on a master AXI-Stream port with full backpressure.
- Uses credit counting so no in-flight product is ever dropped. Sits between the DMA/stream source and the FFT stage.

Parameters:
- MUL_LAT, 3: edges from multiplier sampling en=1 to valid_o=1 for that operand pair; must match the instantiated multiplier.
- DEPTH, 8: output FIFO entries. Requires DEPTH >= MUL_LAT+2 for 1 beat/cycle throughput; DEPTH >= 1 is legal.

Ports:
- clk, input, 1: single clock, rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- s_axis_tdata, input, 16: {a[15:8], b[7:0]}, both unsigned.
- s_axis_tvalid, input, 1: operand beat valid.
- s_axis_tlast, input, 1: end of packet, passed through.
- s_axis_tready, output, 1: adapter can accept a beat.
- m_axis_tdata, output, 16: a*b, unsigned.
- m_axis_tvalid, output, 1: product beat valid.
- m_axis_tlast, output, 1: tlast of the originating input beat.
- m_axis_tready, input, 1: downstream accepts.

Behaviour:
- Clock and reset: one clock domain, clk; reset is asynchronous and active-low on rst_n. All flops clear immediately on rst_n=0.
- Reset values: s_axis_tready=0, m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0; occupancy counter=0; FIFO empty; tlast shift line cleared; multiplier held in reset.
- ready_en flop: resets to 0 and sets on the first clk edge after rst_n rises.
- s_axis_tready = ready_en && (occ < DEPTH). It depends only on registers, with no combinational path from s_axis_tvalid or m_axis_tready.
- Accept: acc = s_axis_tvalid && s_axis_tready.
  - Multiplier en = acc, a_i = tdata[15:8], b_i = tdata[7:0], all combinational, so the multiplier samples them at the accepting edge.
- tlast sideband: a MUL_LAT-deep shift register, advancing every cycle, with bit0 = acc ? s_axis_tlast : 0. Its output is aligned with valid_o.
- Capture: when valid_o=1, {tlast_line_out, p_o} is written into the FIFO at that edge.
- Credit guarantee: occ = beats in flight + FIFO count. A write can never find the FIFO full; an assertion flags a write to a full FIFO.
- occ update per edge:
  - acc and no pop: +1.
  - pop and no acc: -1.
  - both: unchanged.
  - pop = m_axis_tvalid && m_axis_tready.
- Output: m_axis_* reflect the FIFO head, registered. m_axis_tvalid = FIFO non-empty.
  - Data and last hold stable while tvalid=1 and tready=0.
  - Beats leave in acceptance order.
- Latency: a beat accepted at edge N is visible on m_axis with tvalid=1 in the cycle after edge N+MUL_LAT+1 (4 edges by default), given an empty FIFO.
- Empty FIFO with valid_o write: the head appears the next cycle; there is no same-cycle bypass.
- Full FIFO with pop and valid_o write in the same edge: both occur and the count is unchanged.
- Wrap: read and write pointers are mod DEPTH; the count distinguishes full from empty.
- Reset mid-stream: all in-flight and buffered beats are discarded. No beat appears on m_axis after rst_n rises until new input arrives.
- Arithmetic: 8x8 unsigned to a 16-bit product, with no truncation or saturation.

Optional Feature:
- Macro: AXIS_MUL_PERF_CNT_EN.
- Defined:
  - Adds output ports beat_cnt_o[31:0], the count of m_axis handshakes.
  - Adds output ports stall_cnt_o[31:0], the count of cycles with m_axis_tvalid=1 and m_axis_tready=0.
  - Both reset to 0 and wrap at 2^32.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset release then a single beat a=0x55, b=0xAA, tlast=1, m_axis_tready=1 -> m_axis_tdata=0x3872 (14450), tlast=1, tvalid high exactly 4 edges after the accepting edge; s_axis_tready=0 during reset and 1 one cycle after release.
- Back-to-back stream (255,1), (128,2), (200,50), (7,13), (0,150), (255,255), one per cycle, m_axis_tready=1 -> outputs 255, 256, 10000, 91, 0, 65025 in order; s_axis_tready never drops; no bubbles.
- m_axis_tready=0 while streaming 12 beats -> s_axis_tready falls after exactly 8 accepts (occ=8); there is no loss. Then raise m_axis_tready -> all 12 products emerge in order with stable data during stall.
- Random m_axis_tready (50%) and random s_axis_tvalid, 1000 beats -> scoreboard matches a*b and tlast; occ never exceeds 8; no FIFO overflow assertion.
- Assert rst_n=0 with 3 beats in flight and 2 buffered -> m_axis_tvalid=0 immediately; after release no stale beat appears; a new beat (15,15) yields 225.
- With AXIS_MUL_PERF_CNT_EN defined, 10 beats with tready held low 5 cycles while valid -> beat_cnt_o=10, stall_cnt_o=5.
